ram_sim: RTL and testbench

RAM_SIM -- requirements
Module: ram_sim

---
 rtl/ram_sim.sv | 104 ++++++++++
 tb/tb_ram_sim.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sim.sv
// Simple dual-port RAM model with zero-fill sweep after reset.
// Optional second read register: define RAMSIM_OUTREG_EN.
module ram_sim #(
    parameter int DATA_W = 40,
    parameter int ADDR_W = 7
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WrEnable,
    input  logic [DATA_W-1:0] WrData,
    input  logic [ADDR_W-1:0] AddressWR,
    input  logic              RdEnable,
    input  logic [ADDR_W-1:0] AddressRD,
    output logic [DATA_W-1:0] RdData,
    output logic              BusyWR,
    output logic              BusyRD
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        S_SWEEP,
        S_LAST,
        S_READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              sweep_we;
    logic              busy;
    logic              wr_go;
    logic              rd_go;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The extra S_LAST cycle keeps busy up one edge past the final clear.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_we  = 1'b0;
        unique case (state)
            S_SWEEP: begin
                sweep_we = 1'b1;
                cnt_nxt  = cnt + ADDR_W'(1);
                if (cnt == CNT_LAST)
                    state_nxt = S_LAST;
            end
            S_LAST:  state_nxt = S_READY;
            S_READY: state_nxt = S_READY;
            default: state_nxt = S_SWEEP;
        endcase
    end

    assign busy   = (state != S_READY);
    assign BusyWR = busy;
    assign BusyRD = busy;
    assign wr_go  = WrEnable & ~busy;
    assign rd_go  = RdEnable & ~busy;

    // Array has no reset; the sweep defines its contents.
    always_ff @(posedge Clock) begin
        if (sweep_we)
            mem[cnt] <= '0;
        else if (wr_go)
            mem[AddressWR] <= WrData;
    end

    // Nonblocking array update gives read-first on address collision.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            rd_q <= '0;
        else if (rd_go)
            rd_q <= mem[AddressRD];
    end

`ifdef RAMSIM_OUTREG_EN
    logic [DATA_W-1:0] rd_q2;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            rd_q2 <= '0;
        else if (rd_go)
            rd_q2 <= rd_q;
    end

    assign RdData = rd_q2;
`else
    assign RdData = rd_q;
`endif

endmodule

// File: tb/tb_ram_sim.sv
// Directed self-checking bench for ram_sim (default 1-cycle read build).
// Each task drives one scenario and checks results inline.
module tb_ram_sim;

    localparam int DW = 40;
    localparam int AW = 7;

    logic          Clock;
    logic          Reset;
    logic          WrEnable;
    logic [DW-1:0] WrData;
    logic [AW-1:0] AddressWR;
    logic          RdEnable;
    logic [AW-1:0] AddressRD;
    logic [DW-1:0] RdData;
    logic          BusyWR;
    logic          BusyRD;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [128];

    ram_sim #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .WrEnable(WrEnable),
        .WrData(WrData),
        .AddressWR(AddressWR),
        .RdEnable(RdEnable),
        .AddressRD(AddressRD),
        .RdData(RdData),
        .BusyWR(BusyWR),
        .BusyRD(BusyRD)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        WrEnable  = 1'b1;
        AddressWR = a;
        WrData    = d;
        tick();
        WrEnable  = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        RdEnable  = 1'b1;
        AddressRD = a;
        tick();
        RdEnable  = 1'b0;
    endtask

    // Counts edges from release until busy drops; expects 129.
    task automatic wait_init(input string name);
        int  n;
        bit  rd_bad;
        n      = 0;
        rd_bad = 0;
        while (n < 400) begin
            tick();
            n++;
            if (RdData !== '0) rd_bad = 1;
            if (BusyWR === 1'b0) break;
        end
        checks++;
        if (n !== 129) begin
            errors++;
            $display("FAIL %s_busy_edges got %0d want 129", name, n);
        end
        checks++;
        if (BusyRD !== 1'b0) begin
            errors++;
            $display("FAIL %s_busyrd got %b want 0", name, BusyRD);
        end
        checks++;
        if (rd_bad) begin
            errors++;
            $display("FAIL %s_rddata_sweep nonzero during sweep want 0", name);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        checks++;
        if (RdData !== '0) begin
            errors++;
            $display("FAIL rst_rddata got %h want 0", RdData);
        end
        checks++;
        if (BusyWR !== 1'b1 || BusyRD !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy got %b%b want 11", BusyWR, BusyRD);
        end
        Reset = 1'b1;
        wait_init("init");
    endtask

    task automatic test_basic();
        do_write(7'd5, 40'h12_3456_789A);
        do_read(7'd5);
        checks++;
        if (RdData !== 40'h12_3456_789A) begin
            errors++;
            $display("FAIL basic_rd5 got %h want 123456789a", RdData);
        end
        tick();
        tick();
        checks++;
        if (RdData !== 40'h12_3456_789A) begin
            errors++;
            $display("FAIL basic_hold got %h want 123456789a", RdData);
        end
        do_read(7'd9);
        checks++;
        if (RdData !== '0) begin
            errors++;
            $display("FAIL unwritten_rd9 got %h want 0", RdData);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        for (int a = 1; a <= 110; a++)
            model[a] = {8'(a), 32'(a * 32'h9E37_79B9)};
        WrEnable = 1'b1;
        for (int a = 1; a <= 110; a++) begin
            AddressWR = 7'(a);
            WrData    = model[a];
            tick();
        end
        WrEnable = 1'b0;
        bad = 0;
        RdEnable = 1'b1;
        for (int a = 20; a < 70; a++) begin
            AddressRD = 7'(a);
            tick();
            checks++;
            if (RdData !== model[a]) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL b2b_rd%0d got %h want %h", a, RdData, model[a]);
            end
        end
        RdEnable = 1'b0;
        AddressRD = 7'd100;
        tick();
        tick();
        checks++;
        if (RdData !== model[69]) begin
            errors++;
            $display("FAIL b2b_hold got %h want %h", RdData, model[69]);
        end
    endtask

    task automatic test_read_first();
        do_write(7'd3, 40'h11_1111_1111);
        WrEnable  = 1'b1;
        AddressWR = 7'd3;
        WrData    = 40'hAA_AAAA_AAAA;
        RdEnable  = 1'b1;
        AddressRD = 7'd3;
        tick();
        WrEnable  = 1'b0;
        RdEnable  = 1'b0;
        checks++;
        if (RdData !== 40'h11_1111_1111) begin
            errors++;
            $display("FAIL rf_old got %h want 1111111111", RdData);
        end
        do_read(7'd3);
        checks++;
        if (RdData !== 40'hAA_AAAA_AAAA) begin
            errors++;
            $display("FAIL rf_new got %h want aaaaaaaaaa", RdData);
        end
    endtask

    task automatic test_abort();
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (RdData !== '0 || BusyWR !== 1'b1 || BusyRD !== 1'b1) begin
            errors++;
            $display("FAIL async_rst got %h %b%b want 0 11", RdData, BusyWR, BusyRD);
        end
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        do_write(7'd0, 40'hDE_ADBE_EF01);
        do_read(7'd0);
        checks++;
        if (RdData !== '0 || BusyWR !== 1'b1) begin
            errors++;
            $display("FAIL sweep_drop got %h %b want 0 1", RdData, BusyWR);
        end
        for (int i = 0; i < 40; i++) tick();
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (BusyWR !== 1'b1 || BusyRD !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy got %b%b want 11", BusyWR, BusyRD);
        end
        tick();
        Reset = 1'b1;
        fork
            wait_init("restart");
            begin
                for (int i = 0; i < 50; i++) tick();
                WrEnable  = 1'b1;
                AddressWR = 7'd0;
                WrData    = 40'h55_5555_5555;
                tick();
                WrEnable  = 1'b0;
            end
        join
        do_read(7'd0);
        checks++;
        if (RdData !== '0) begin
            errors++;
            $display("FAIL abort_rd0 got %h want 0", RdData);
        end
        do_read(7'd3);
        checks++;
        if (RdData !== '0) begin
            errors++;
            $display("FAIL abort_rd3 got %h want 0", RdData);
        end
    endtask

    initial begin
        Reset     = 1'b0;
        WrEnable  = 1'b0;
        WrData    = '0;
        AddressWR = '0;
        RdEnable  = 1'b0;
        AddressRD = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_read_first();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
